// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU share arbiter.
// Holds the operand/op widths, the funct-coded ALU op codes and the arbiter FSM
// state encoding. The ALU itself lives outside the arbiter.
// Macros: none here (ALU_ARB_LOCK_EN is consumed by alu_share_arbiter).
package alu_defs_pkg;

    localparam int N_BITS  = 32;
    localparam int OP_BITS = 6;

    localparam logic [OP_BITS-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_BITS-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_BITS-1:0] OP_AND = 6'b100100;
    localparam logic [OP_BITS-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_BITS-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_BITS-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_BITS-1:0] OP_SLT = 6'b101010;
    localparam logic [OP_BITS-1:0] OP_SRL = 6'b000010;
    localparam logic [OP_BITS-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_BITS-1:0] OP_LUI = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request / ALU / response bundle of the ALU share arbiter.
//   slave  : the arbiter side (takes requests, drives ALU operands and responses)
//   master : the environment side (requesters, external ALU, response consumer)
// Signals:
//   i_req_valid/a/b/op/lock : packed per requester, req0 in the low half
//   o_req_ready             : one-hot accept
//   o_alu_a/b/op, i_alu_result : connection to the shared combinational ALU
//   o_rsp_valid/id/data, i_rsp_ready : response handshake
interface alu_share_arbiter_if;
    import alu_defs_pkg::*;

    logic [1:0]           i_req_valid;
    logic [2*N_BITS-1:0]  i_req_a;
    logic [2*N_BITS-1:0]  i_req_b;
    logic [2*OP_BITS-1:0] i_req_op;
    logic [1:0]           i_req_lock;
    logic [1:0]           o_req_ready;
    logic [N_BITS-1:0]    o_alu_a;
    logic [N_BITS-1:0]    o_alu_b;
    logic [OP_BITS-1:0]   o_alu_op;
    logic [N_BITS-1:0]    i_alu_result;
    logic                 o_rsp_valid;
    logic                 o_rsp_id;
    logic [N_BITS-1:0]    o_rsp_data;
    logic                 i_rsp_ready;

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_req_op, i_req_lock,
        input  i_alu_result, i_rsp_ready,
        output o_req_ready, o_alu_a, o_alu_b, o_alu_op,
        output o_rsp_valid, o_rsp_id, o_rsp_data
    );

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_req_op, i_req_lock,
        output i_alu_result, i_rsp_ready,
        input  o_req_ready, o_alu_a, o_alu_b, o_alu_op,
        input  o_rsp_valid, o_rsp_id, o_rsp_data
    );

endinterface

// File: rtl/alu_rr_pick.sv
// Combinational 2-way round-robin picker.
// Ports:
//   valid    in  2  per-requester valid
//   ptr      in  1  requester that won last; on a tie the other one wins
//   lock_act in  1  grant restricted to lock_id
//   lock_id  in  1  locked owner
//   grant    out 2  one-hot grant (zero when nothing eligible)
module alu_rr_pick (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       lock_act,
    input  logic       lock_id,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (lock_act) begin
            grant[lock_id] = valid[lock_id];
        end else begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters (req0 = EX helper,
// req1 = debug/test port). One operation in flight; operands registered before the
// ALU, result registered after it. Accept -> o_rsp_valid latency is 2 cycles.
// Ports:
//   i_clk    in  clock, rising edge
//   i_rst_n  in  asynchronous reset, active low
//   bus      slave modport of alu_share_arbiter_if (requests, ALU, response)
// Macro: ALU_ARB_LOCK_EN enables grant locking through i_req_lock; undefined means
//   pure round-robin and i_req_lock is ignored.
//
// state | meaning
// IDLE  | offering a one-hot ready to the round-robin winner
// EXEC  | operands stable at the ALU, result captured at the end of this cycle
// RESP  | response valid, held until i_rsp_ready
module alu_share_arbiter
    import alu_defs_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    alu_share_arbiter_if.slave  bus
);

    arb_state_e          state;
    logic                ptr_q;
    logic                id_q;
    logic [N_BITS-1:0]   alu_a_q;
    logic [N_BITS-1:0]   alu_b_q;
    logic [OP_BITS-1:0]  alu_op_q;
    logic                rsp_valid_q;
    logic [N_BITS-1:0]   rsp_data_q;
    logic [1:0]          grant;
    logic [1:0]          ready;
    logic                accept;
    logic                win;
    logic                lock_act;

`ifdef ALU_ARB_LOCK_EN
    logic lock_q;
    // The lock owner is always the last winner, so ptr_q doubles as the owner id.
    assign lock_act = lock_q & bus.i_req_valid[ptr_q] & bus.i_req_lock[ptr_q];
`else
    logic unused_lock;
    assign unused_lock = ^bus.i_req_lock;
    assign lock_act    = 1'b0;
`endif

    alu_rr_pick u_pick (
        .valid    (bus.i_req_valid),
        .ptr      (ptr_q),
        .lock_act (lock_act),
        .lock_id  (ptr_q),
        .grant    (grant)
    );

    // Gated by i_rst_n so ready stays low while reset is held.
    assign ready  = (state == ST_IDLE && i_rst_n) ? grant : 2'b00;
    assign accept = |(bus.i_req_valid & ready);
    assign win    = ready[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            ptr_q       <= 1'b1;
            id_q        <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef ALU_ARB_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef ALU_ARB_LOCK_EN
                    if (!lock_act) lock_q <= 1'b0;
`endif
                    if (accept) begin
                        alu_a_q  <= win ? bus.i_req_a[2*N_BITS-1:N_BITS]   : bus.i_req_a[N_BITS-1:0];
                        alu_b_q  <= win ? bus.i_req_b[2*N_BITS-1:N_BITS]   : bus.i_req_b[N_BITS-1:0];
                        alu_op_q <= win ? bus.i_req_op[2*OP_BITS-1:OP_BITS] : bus.i_req_op[OP_BITS-1:0];
                        id_q     <= win;
                        ptr_q    <= win;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q  <= bus.i_alu_result;
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        alu_a_q     <= '0;
                        alu_b_q     <= '0;
                        alu_op_q    <= '0;
`ifdef ALU_ARB_LOCK_EN
                        lock_q      <= bus.i_req_lock[id_q];
`endif
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_req_ready = ready;
    assign bus.o_alu_a     = alu_a_q;
    assign bus.o_alu_b     = alu_b_q;
    assign bus.o_alu_op    = alu_op_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_id    = id_q;
    assign bus.o_rsp_data  = rsp_data_q;

endmodule
